// File: rtl/spi_master_pkg.sv
// Shared types for the APB SPI master transmit path.
// State encoding and per-edge shift steps.
package spi_master_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        TRANSMIT
    } tx_state_e;

    localparam int unsigned STEP_STD  = 1;
    localparam int unsigned STEP_QUAD = 4;

endpackage

// File: rtl/spi_master_tx_shifter.sv
// SPI master TX shifter: pops FIFO words and shifts them out MSB-first
// on one (standard) or four (quad) data lines, one step per SPI edge.
module spi_master_tx_shifter
    import spi_master_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic                  tx_edge_i,
    input  logic                  quad_i,
    input  logic [CNT_WIDTH-1:0]  counter_in_i,
    input  logic                  counter_in_upd_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic                  clk_en_o,
    output logic                  sdo0_o,
    output logic                  sdo1_o,
    output logic                  sdo2_o,
    output logic                  sdo3_o,
    output logic                  done_o
);

    localparam int WW = $clog2(DATA_WIDTH + 1);

    tx_state_e             r_state;
    logic [DATA_WIDTH-1:0] r_sr;
    logic [CNT_WIDTH:0]    r_cnt;
    logic [WW-1:0]         r_wcnt;
    logic [CNT_WIDTH-1:0]  r_len;
    logic                  r_quad;
    logic                  r_done;
    logic                  r_clk_en;

    logic [CNT_WIDTH:0]    w_step;
    logic [WW-1:0]         w_wstep;
    logic [CNT_WIDTH-1:0]  w_len;
    logic [CNT_WIDTH:0]    w_cnt_next;
    logic [WW-1:0]         w_wcnt_next;
    logic                  w_end_edge;
    logic                  w_word_end;
    logic                  w_wait_end;
    logic                  w_start;
    logic                  w_pop;
    logic                  w_tx;

    assign w_step  = r_quad ? (CNT_WIDTH+1)'(STEP_QUAD)
                            : (CNT_WIDTH+1)'(STEP_STD);
    assign w_wstep = r_quad ? WW'(STEP_QUAD) : WW'(STEP_STD);

    // A mid-transfer length update takes effect in the same cycle's compare.
    assign w_len = (r_state != IDLE && counter_in_upd_i)
                 ? counter_in_i : r_len;

    assign w_cnt_next  = r_cnt + w_step;
    assign w_wcnt_next = r_wcnt + w_wstep;
    assign w_end_edge  = w_cnt_next >= {1'b0, w_len};
    assign w_word_end  = w_wcnt_next == WW'(DATA_WIDTH);
    assign w_wait_end  = {1'b0, w_len} <= r_cnt;
    assign w_start     = en_i && (counter_in_i != '0);

    always_comb begin
        w_pop = 1'b0;
        unique case (r_state)
            IDLE:      w_pop = w_start && data_valid_i;
            WAIT_DATA: w_pop = data_valid_i && !w_wait_end;
            TRANSMIT:  w_pop = tx_edge_i && !w_end_edge
                             && w_word_end && data_valid_i;
            default:   w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_sr     <= '0;
            r_cnt    <= '0;
            r_wcnt   <= '0;
            r_len    <= '0;
            r_quad   <= 1'b0;
            r_done   <= 1'b0;
            r_clk_en <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (en_i) begin
                        if (!w_start) begin
                            r_done <= 1'b1;
                        end else begin
                            r_len  <= counter_in_i;
                            r_quad <= quad_i;
                            r_cnt  <= '0;
                            r_wcnt <= '0;
                            if (data_valid_i) begin
                                r_sr     <= data_i;
                                r_state  <= TRANSMIT;
                                r_clk_en <= 1'b1;
                            end else begin
                                r_state <= WAIT_DATA;
                            end
                        end
                    end
                end
                WAIT_DATA: begin
                    r_len <= w_len;
                    if (w_wait_end) begin
                        r_done  <= 1'b1;
                        r_sr    <= '0;
                        r_state <= IDLE;
                    end else if (data_valid_i) begin
                        r_sr     <= data_i;
                        r_wcnt   <= '0;
                        r_state  <= TRANSMIT;
                        r_clk_en <= 1'b1;
                    end
                end
                TRANSMIT: begin
                    r_len <= w_len;
                    if (tx_edge_i) begin
                        r_cnt <= w_cnt_next;
                        if (w_end_edge) begin
                            r_done   <= 1'b1;
                            r_sr     <= '0;
                            r_state  <= IDLE;
                            r_clk_en <= 1'b0;
                        end else if (w_word_end) begin
                            r_wcnt <= '0;
                            if (data_valid_i) begin
                                r_sr <= data_i;
                            end else begin
                                r_sr     <= '0;
                                r_state  <= WAIT_DATA;
                                r_clk_en <= 1'b0;
                            end
                        end else begin
                            r_sr   <= r_quad ? (r_sr << 4) : (r_sr << 1);
                            r_wcnt <= w_wcnt_next;
                        end
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_clk_en <= 1'b0;
                end
            endcase
        end
    end

    assign w_tx = (r_state == TRANSMIT);

    assign data_ready_o = w_pop && rst_ni;
    assign clk_en_o     = r_clk_en;
    assign done_o       = r_done;

    assign sdo3_o = w_tx && r_quad && r_sr[DATA_WIDTH-1];
    assign sdo2_o = w_tx && r_quad && r_sr[DATA_WIDTH-2];
    assign sdo1_o = w_tx && r_quad && r_sr[DATA_WIDTH-3];
    assign sdo0_o = w_tx && (r_quad ? r_sr[DATA_WIDTH-4]
                                    : r_sr[DATA_WIDTH-1]);

endmodule

// File: tb/tb_spi_master_tx_shifter.sv
// Directed bench for spi_master_tx_shifter with a FIFO model and an
// expected-output scoreboard popped on every checked shift edge.
module tb_spi_master_tx_shifter;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        en_i = 1'b0;
    logic        tx_edge_i = 1'b0;
    logic        quad_i = 1'b0;
    logic [15:0] counter_in_i = '0;
    logic        counter_in_upd_i = 1'b0;
    logic [31:0] data_i = '0;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic        clk_en_o;
    logic        sdo0_o, sdo1_o, sdo2_o, sdo3_o;
    logic        done_o;

    logic [31:0] fifo_q[$];
    logic [3:0]  sb_q[$];
    int          checks = 0;
    int          failures = 0;
    int          pops = 0;

    spi_master_tx_shifter #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .en_i            (en_i),
        .tx_edge_i       (tx_edge_i),
        .quad_i          (quad_i),
        .counter_in_i    (counter_in_i),
        .counter_in_upd_i(counter_in_upd_i),
        .data_i          (data_i),
        .data_valid_i    (data_valid_i),
        .data_ready_o    (data_ready_o),
        .clk_en_o        (clk_en_o),
        .sdo0_o          (sdo0_o),
        .sdo1_o          (sdo1_o),
        .sdo2_o          (sdo2_o),
        .sdo3_o          (sdo3_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        data_valid_i = (fifo_q.size() != 0);
        data_i = data_valid_i ? fifo_q[0] : '0;
    endtask

    task automatic push(input logic [31:0] w, input int nb, input logic q);
        fifo_q.push_back(w);
        refresh();
        if (q) begin
            for (int i = 0; i < nb / 4; i++) sb_q.push_back(w[31-4*i -: 4]);
        end else begin
            for (int i = 0; i < nb; i++) sb_q.push_back({3'b000, w[31-i]});
        end
    endtask

    task automatic cyc(input logic edge_v, input logic sc);
        logic       popped;
        logic [3:0] exp;
        logic [31:0] dummy;
        tx_edge_i = edge_v;
        #1;
        popped = data_ready_o;
        if (popped) begin
            chk("pop_valid", {31'd0, data_valid_i}, 32'd1);
            pops++;
        end
        if (sc) begin
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_underflow observed=empty expected=entry");
            end else begin
                exp = sb_q.pop_front();
                chk("sdo", {28'd0, sdo3_o, sdo2_o, sdo1_o, sdo0_o},
                    {28'd0, exp});
            end
        end
        @(posedge clk_i);
        #1;
        if (popped && fifo_q.size() != 0) begin
            dummy = fifo_q.pop_front();
            refresh();
        end
        tx_edge_i = 1'b0;
        en_i = 1'b0;
        counter_in_upd_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic edges(input int n, input int gap, input logic sc);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, sc);
            for (int j = 1; j < gap; j++) cyc(1'b0, 1'b0);
        end
    endtask

    task automatic finish_xfer(input int n, input int gap, input string t);
        edges(n - 1, gap, 1'b1);
        cyc(1'b1, 1'b1);
        chk({t, "_done_hi"}, {31'd0, done_o}, 32'd1);
        chk({t, "_clken_lo"}, {31'd0, clk_en_o}, 32'd0);
        cyc(1'b0, 1'b0);
        chk({t, "_done_lo"}, {31'd0, done_o}, 32'd0);
        chk({t, "_sb_left"}, sb_q.size(), 32'd0);
    endtask

    task automatic start(input logic [15:0] len, input logic q);
        counter_in_i = len;
        quad_i = q;
        en_i = 1'b1;
        cyc(1'b0, 1'b0);
        quad_i = 1'b0;
    endtask

    initial begin
        refresh();
        @(negedge clk_i);
        @(negedge clk_i);
        chk("rst_outs", {26'd0, data_ready_o, clk_en_o, done_o,
            sdo3_o, sdo2_o, sdo1_o}, 32'd0);
        chk("rst_sdo0", {31'd0, sdo0_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // standard 8 bits
        pops = 0;
        push(32'hA500_0000, 8, 1'b0);
        start(16'd8, 1'b0);
        chk("t1_pop", pops, 32'd1);
        chk("t1_clken", {31'd0, clk_en_o}, 32'd1);
        finish_xfer(8, 4, "t1");
        chk("t1_pops", pops, 32'd1);

        // quad 64 bits
        pops = 0;
        push(32'h1234_5678, 32, 1'b1);
        push(32'h9ABC_DEF0, 32, 1'b1);
        start(16'd64, 1'b1);
        edges(7, 2, 1'b1);
        chk("t2_pops7", pops, 32'd1);
        cyc(1'b1, 1'b1);
        chk("t2_pop8", pops, 32'd2);
        chk("t2_clken8", {31'd0, clk_en_o}, 32'd1);
        cyc(1'b0, 1'b0);
        chk("t2_clken9", {31'd0, clk_en_o}, 32'd1);
        finish_xfer(8, 2, "t2");
        chk("t2_pops", pops, 32'd2);

        // standard 40 bits with FIFO underrun
        pops = 0;
        push(32'hFFFF_FFFF, 32, 1'b0);
        start(16'd40, 1'b0);
        edges(32, 2, 1'b1);
        chk("t3_gated", {31'd0, clk_en_o}, 32'd0);
        for (int i = 0; i < 10; i++) cyc(logic'(i % 2), 1'b0);
        chk("t3_gated2", {31'd0, clk_en_o}, 32'd0);
        chk("t3_sdo_idle", {28'd0, sdo3_o, sdo2_o, sdo1_o, sdo0_o}, 32'd0);
        chk("t3_pops1", pops, 32'd1);
        push(32'h8000_0000, 8, 1'b0);
        cyc(1'b0, 1'b0);
        chk("t3_pops2", pops, 32'd2);
        chk("t3_clken", {31'd0, clk_en_o}, 32'd1);
        finish_xfer(8, 2, "t3");

        // zero length
        pops = 0;
        fifo_q.push_back(32'hFFFF_FFFF);
        refresh();
        start(16'd0, 1'b0);
        chk("t4_done", {31'd0, done_o}, 32'd1);
        chk("t4_nopop", pops, 32'd0);
        chk("t4_sdo", {28'd0, sdo3_o, sdo2_o, sdo1_o, sdo0_o}, 32'd0);
        chk("t4_clken", {31'd0, clk_en_o}, 32'd0);
        cyc(1'b0, 1'b0);
        chk("t4_done_lo", {31'd0, done_o}, 32'd0);
        fifo_q.delete();
        refresh();

        // length update mid-transfer
        pops = 0;
        push(32'hC3C3_C3C3, 8, 1'b0);
        start(16'd32, 1'b0);
        edges(4, 2, 1'b1);
        counter_in_i = 16'd8;
        counter_in_upd_i = 1'b1;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        chk("t5_running", {31'd0, clk_en_o}, 32'd1);
        finish_xfer(3, 2, "t5");
        chk("t5_pops", pops, 32'd1);

        // async reset mid-transfer
        pops = 0;
        push(32'hDEAD_BEEF, 32, 1'b0);
        start(16'd32, 1'b0);
        edges(9, 2, 1'b1);
        tx_edge_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_outs", {25'd0, data_ready_o, clk_en_o, done_o,
            sdo3_o, sdo2_o, sdo1_o, sdo0_o}, 32'd0);
        tx_edge_i = 1'b0;
        sb_q.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        pops = 0;
        push(32'h5A00_0000, 8, 1'b0);
        start(16'd8, 1'b0);
        chk("t6_fresh_pop", pops, 32'd1);
        finish_xfer(8, 2, "t6");
        chk("t6_fifo_empty", fifo_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
